// File: rtl/reg4_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit load/clear/set register among N_REQ requesters.
// Latency: grant 1 cycle after req; owner's op lands on q at each granted edge. Locked bursts capped at MAX_BURST.
module reg4_share_arbiter #(
    parameter int N_REQ     = 3,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [2:0]             owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t           state;
    logic [2:0]       rr_ptr;
    logic [3:0]       burst_cnt;
    logic [2:0]       nxt_ptr;
    logic [2:0]       arb_ptr;
    logic [2:0]       win;
    logic             found;
    logic             own_req;
    logic             own_lock;
    logic [1:0]       own_op;
    logic [WIDTH-1:0] own_din;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_op   = 2'b00;
        own_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == 3'(i)) begin
                own_req  = req[i];
                own_lock = lock[i];
                own_op   = op[2*i +: 2];
                own_din  = din[WIDTH*i +: WIDTH];
            end
        end
    end

    assign nxt_ptr = (owner == 3'(N_REQ-1)) ? 3'd0 : owner + 3'd1;
    // On release the pointer update and arbitration share the same edge.
    assign arb_ptr = (state == OWNED) ? nxt_ptr : rr_ptr;

    // First pass covers [arb_ptr, N_REQ); second pass wraps to the low indices.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) >= arb_ptr)) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= 3'd0;
            busy      <= 1'b0;
            q         <= '0;
            rr_ptr    <= 3'd0;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OWNED;
                        gnt       <= ONE << win;
                        owner     <= win;
                        busy      <= 1'b1;
                        burst_cnt <= 4'd1;
                    end
                end
                OWNED: begin
                    if (own_req) begin
                        case (own_op)
                            2'b01:   q <= own_din;
                            2'b10:   q <= '0;
                            2'b11:   q <= '1;
                            default: q <= q;
                        endcase
                    end
                    if (own_req && own_lock && (burst_cnt < 4'(MAX_BURST))) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        rr_ptr <= nxt_ptr;
                        if (found) begin
                            gnt       <= ONE << win;
                            owner     <= win;
                            burst_cnt <= 4'd1;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            busy      <= 1'b0;
                            burst_cnt <= 4'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg4_share_arbiter.sv
// Self-checking bench for reg4_share_arbiter: per-cycle expectations queued on drive, checked after each edge.
module tb_reg4_share_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [5:0]  op;
    logic [11:0] din;
    logic [2:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic [3:0]  q;

    int n_cmp;
    int n_err;

    logic [10:0] sb[$];
    logic [10:0] e;
    wire  [10:0] obs = {busy, owner, gnt, q};

    reg4_share_arbiter #(.N_REQ(3), .WIDTH(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .op(op), .din(din),
        .gnt(gnt), .owner(owner), .busy(busy), .q(q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic b, input logic [2:0] o,
                                       input logic [2:0] g, input logic [3:0] qv);
        return {b, o, g, qv};
    endfunction

    task automatic do_reset();
        reset = 1'b0; req = '0; lock = '0; op = '0; din = '0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; lock = '0; op = '0; din = '0;
        #3;
        sb.push_back(mk(0, 0, 3'b000, 4'h0));
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset: got %h expected %h", obs, e); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single_load();
        logic [2:0]  rq[3]  = '{3'b001, 3'b001, 3'b000};
        logic [10:0] ex[3]  = '{mk(1,0,3'b001,4'h0), mk(1,0,3'b001,4'hA), mk(0,0,3'b000,4'hA)};
        do_reset();
        op = 6'b000001; din = 12'h00A; lock = '0;
        for (int k = 0; k < 3; k++) begin
            req = rq[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL single_load[%0d]: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  rq[6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
        logic [10:0] ex[6] = '{mk(1,0,3'b001,4'h0), mk(1,1,3'b010,4'h1), mk(1,2,3'b100,4'h2),
                               mk(1,0,3'b001,4'h3), mk(1,1,3'b010,4'h1), mk(0,1,3'b000,4'h1)};
        do_reset();
        op = 6'b010101; din = 12'h321; lock = '0;
        for (int k = 0; k < 6; k++) begin
            req = rq[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL round_robin[%0d]: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_burst_limit();
        logic [2:0]  rq[8] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
        logic [10:0] ex[8] = '{mk(1,0,3'b001,4'h0), mk(1,0,3'b001,4'hF), mk(1,0,3'b001,4'hF),
                               mk(1,0,3'b001,4'hF), mk(1,1,3'b010,4'hF), mk(1,0,3'b001,4'h5),
                               mk(1,0,3'b001,4'hF), mk(0,0,3'b000,4'hF)};
        do_reset();
        op = 6'b000111; din = 12'h050; lock = 3'b001;
        for (int k = 0; k < 8; k++) begin
            req = rq[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL burst_limit[%0d]: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_owner_drop();
        logic [2:0]  rq[5] = '{3'b001, 3'b001, 3'b011, 3'b010, 3'b000};
        logic [2:0]  lk[5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
        logic [5:0]  opv[5] = '{6'b000001, 6'b000001, 6'b000010, 6'b000010, 6'b000010};
        logic [10:0] ex[5] = '{mk(1,0,3'b001,4'h0), mk(1,0,3'b001,4'h5), mk(1,0,3'b001,4'h0),
                               mk(1,1,3'b010,4'h0), mk(0,1,3'b000,4'h0)};
        do_reset();
        din = 12'h005;
        for (int k = 0; k < 5; k++) begin
            req = rq[k]; lock = lk[k]; op = opv[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL owner_drop[%0d]: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] ex[2] = '{mk(1,2,3'b100,4'h0), mk(1,2,3'b100,4'hC)};
        do_reset();
        req = 3'b100; lock = 3'b100; op = 6'b010000; din = 12'hC00;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL async_setup[%0d]: got %h expected %h", k, obs, e); end
        end
        #2 reset = 1'b0;
        sb.push_back(mk(0, 0, 3'b000, 4'h0));
        #1;
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_reset: got %h expected %h", obs, e); end
        @(posedge clk); #1;
        req = 3'b110; lock = 3'b000; op = 6'b000000;
        reset = 1'b1;
        sb.push_back(mk(1, 1, 3'b010, 4'h0));
        @(posedge clk); #1;
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_regrant: got %h expected %h", obs, e); end
        sb.push_back(mk(1, 2, 3'b100, 4'h0));
        @(posedge clk); #1;
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_next: got %h expected %h", obs, e); end
    endtask

    task automatic test_set_clear();
        logic [2:0]  rq[5] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b000};
        logic [10:0] ex[5] = '{mk(1,0,3'b001,4'h0), mk(1,2,3'b100,4'h0), mk(1,0,3'b001,4'hF),
                               mk(1,2,3'b100,4'h0), mk(0,2,3'b000,4'h0)};
        do_reset();
        op = 6'b110010; din = 12'h000; lock = '0;
        for (int k = 0; k < 5; k++) begin
            req = rq[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL set_clear[%0d]: got %h expected %h", k, obs, e); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_burst_limit();
        test_owner_drop();
        test_async_reset();
        test_set_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg4_share_arbiter.md
Name: reg4_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit storage register (load/clear/set semantics) among N_REQ requesters.
- Grants ownership of the register to one requester at a time.
- Applies the owner's operation each granted cycle.
- Supports locked bursts bounded by MAX_BURST so that no requester starves.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- WIDTH, 4, width of the shared register
- MAX_BURST, 4, maximum consecutive granted cycles per ownership (1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset)
- req  input  N_REQ  request per requester, level, held until served
- lock  input  N_REQ  owner asks to keep grant for a burst
- op  input  2*N_REQ  per-requester op, slice [2i+1:2i]: 00 hold, 01 load din, 10 clear, 11 set all ones
- din  input  WIDTH*N_REQ  per-requester load data, slice [WIDTH*i+WIDTH-1:WIDTH*i]
- gnt  output  N_REQ  registered one-hot grant
- owner  output  3  index of current owner, valid when busy=1
- busy  output  1  1 when state=OWNED
- q  output  WIDTH  shared register contents

Behaviour:
- Reset (reset=0, immediate, independent of clk): q=0, gnt=0, owner=0, busy=0, state=IDLE, rr_ptr=0, burst_cnt=0.
- States: IDLE, OWNED.
- IDLE:
  - If any req bit is 1 at an edge, select the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Next cycle: gnt[i]=1, owner=i, busy=1, burst_cnt=1, state=OWNED.
  - Grant latency from req is 1 cycle. No op is applied in IDLE; q holds.
- OWNED, owner i, at each rising edge:
  - Op apply: if req[i]=1, q <= per op[i]: 00 q, 01 din[i], 10 all zeros, 11 all ones. If req[i]=0, q holds.
  - Continue: req[i]=1 and lock[i]=1 and burst_cnt<MAX_BURST -> stay, burst_cnt+1.
  - Release otherwise. On release, rr_ptr <= (i+1) mod N_REQ, and arbitration runs in the same edge with the new pointer over the current req.
    - If a winner j exists, go directly to OWNED(j) with gnt one-hot j and burst_cnt=1. There is no idle bubble.
    - If i is still requesting, it is eligible only after all others; a sole requester is re-granted with burst_cnt=1.
    - If no req is pending: state=IDLE, gnt=0, busy=0.
  - With lock[i]=0, ownership lasts exactly 1 cycle (single op).
- Only the owner's op/din are ever used; ops from non-owners are ignored.
- gnt is never more than one-hot. A change of owner is visible on gnt in the cycle after the release edge.
- rr_ptr changes only on release; rr_ptr=0 after reset gives requester 0 first priority.
- Reset asserted mid-burst aborts immediately: no partial op, and q=0.
- First edge after reset deassertion behaves as IDLE.
- burst_cnt width is 4 bits; it never exceeds MAX_BURST.
- owner holds its last value when busy=0.

Test Plan:
- Single load:
  - Stimulus: reset release; req=001, lock=0, op0=01, din0=4'hA.
  - Response: gnt=001 one cycle after req; q=4'hA the edge after. With req0 dropped, next state IDLE, busy=0.
- Round-robin fairness:
  - Stimulus: req=111 continuously, lock=000, op=load, din0=1, din1=2, din2=3.
  - Response: gnt sequence 001,010,100,001 on consecutive cycles; q sequence 1,2,3,1 with no bubbles.
- Burst limit:
  - Stimulus: MAX_BURST=4; req=011, lock0=1, op0=11.
  - Response: gnt=001 for exactly 4 cycles, then 010 for 1 cycle (lock1=0), then back to 001. q=4'hF after the first owner0 edge.
- Owner drops request:
  - Stimulus: owner0 locked, op0=10, with q=4'h5 beforehand; req0 falls in its 2nd granted cycle.
  - Response: q=0 from the first edge; no op at the drop edge; release to req1 if pending, otherwise IDLE.
- Async reset mid-burst:
  - Stimulus: q=4'hC, owner=2 with burst_cnt=2; pull reset low between edges.
  - Response: q=0, gnt=000, busy=0 immediately without a clock edge. After release, req=110 grants requester 1 first (rr_ptr=0).
- Set vs clear ownership:
  - Stimulus: req=101, op0=10, op2=11, lock=0, from IDLE with rr_ptr=0.
  - Response: q=0 after owner0, then 4'hF after owner2. Never both applied in one edge.
